// File: rtl/pa_soc_uart_tx_pkg.sv
// Shared types and helpers for the SoC UART transmitter and its FIFO.
// Fallback rates for builds that do not pull in pa_soc_param.v first.
`ifndef CPU_FREQ_HZ
`define CPU_FREQ_HZ 50_000_000
`endif
`ifndef UART_BAUD_RATE
`define UART_BAUD_RATE 115200
`endif

package pa_soc_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

  localparam int UART_DATA_BITS = 8;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/pa_soc_uart_fifo.sv
// Synchronous FIFO with push/pop, full/empty and occupancy; shared by the UART
// transmitter and, later, the receiver.
module pa_soc_uart_fifo
  import pa_soc_uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("pa_soc_uart_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == LVL_W'(DEPTH));
  assign empty_o = (count == '0);
  assign level_o = count;
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/pa_soc_uart_tx.sv
// SoC-side 8N1 UART transmitter: FIFO-buffered bytes serialised on txd with a
// registered output and back-to-back frames when the FIFO stays non-empty.
module pa_soc_uart_tx
  import pa_soc_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = `CPU_FREQ_HZ,
  parameter int BAUD_RATE   = `UART_BAUD_RATE,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              wr_en_i,
  input  logic [7:0]                        wr_data_i,
  output logic                              wr_ready_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              tx_done_o,
  output logic                              txd
);

  localparam int DIV   = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("pa_soc_uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end

  uart_tx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_d;
  logic             baud_last;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  pa_soc_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (wr_en_i & ~fifo_full),
    .push_data_i (wr_data_i),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  assign wr_ready_o = ~fifo_full;
  assign busy_o     = (state_q != ST_IDLE) | ~fifo_empty;
  assign baud_last  = (cnt_q == CNT_LAST);
  assign tx_done_o  = (state_q == ST_STOP) & baud_last;

  // txd is derived from the next state so the pin flips on the same edge as the FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    txd_d     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd       <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd       <= txd_d;
    end
  end

endmodule

// File: tb/tb_pa_soc_uart_tx.sv
// Directed bench for pa_soc_uart_tx at DIV=16: a line monitor decodes txd frames
// and checks bit widths and tx_done placement; the stimulus block checks the rest.
module tb_pa_soc_uart_tx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 8;
  localparam int DIV    = 16;
  localparam int FRAME  = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       busy;
  logic [3:0] level;
  logic       tx_done;
  logic       txd;

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  logic [7:0] rxQ[$];
  int         rxStart[$];
  int         shapeErr = 0;
  int         doneErr = 0;

  always #5 clk = ~clk;

  pa_soc_uart_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .busy_o     (busy),
    .level_o    (level),
    .tx_done_o  (tx_done),
    .txd        (txd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] data);
    wr_en   = en;
    wr_data = data;
  endtask

  task automatic stepClock;
    @(posedge clk);
    #2;
  endtask

  task automatic clearRx;
    rxQ.delete();
    rxStart.delete();
  endtask

  task automatic waitFrames(input int n, input int budget);
    int left;
    left = budget;
    while (rxQ.size() < n && left > 0) begin
      stepClock;
      left--;
    end
    checkOutput("frame_wait", 32'(rxQ.size()), 32'(n));
  endtask

  function automatic logic [31:0] rxByte(input int i);
    return (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] rxStartAt(input int i);
    return (i < rxStart.size()) ? 32'(rxStart[i]) : 32'hDEAD;
  endfunction

  // Line monitor: samples 1 time unit after each edge, one frame = 160 samples.
  initial begin : uart_monitor
    bit         inFrame;
    int         pos;
    bit         shapeOk;
    int         startCyc;
    logic       bitv[10];
    logic [7:0] b;
    inFrame = 0;
    pos = 0;
    shapeOk = 1;
    startCyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        inFrame = 0;
      end else begin
        if (!inFrame && txd === 1'b0) begin
          inFrame = 1;
          pos = 0;
          shapeOk = 1;
          startCyc = cyc;
        end
        if (inFrame) begin
          if (pos % DIV == 0) bitv[pos / DIV] = txd;
          else if (txd !== bitv[pos / DIV]) shapeOk = 0;
          if (tx_done !== (pos == FRAME - 1)) doneErr++;
          pos++;
          if (pos == FRAME) begin
            inFrame = 0;
            for (int k = 0; k < 8; k++) b[k] = bitv[k + 1];
            rxQ.push_back(b);
            rxStart.push_back(startCyc);
            if (!shapeOk || bitv[0] !== 1'b0 || bitv[9] !== 1'b1) shapeErr++;
          end
        end else if (tx_done !== 1'b0) begin
          doneErr++;
        end
      end
    end
  end

  initial begin : watchdog
    #400_000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int wEdge;
    int accepted;
    int maxLevel;
    int budget;

    // Reset state
    applyStimulus(1'b0, 8'h00);
    repeat (3) stepClock;
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(tx_done), 32'd0);
    #1 rst_n = 1'b1;
    stepClock;

    // 1: single byte 0x55
    $display("[TB] single byte");
    clearRx();
    applyStimulus(1'b1, 8'h55);
    stepClock;
    wEdge = cyc;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_level_after_write", 32'(level), 32'd1);
    checkOutput("t1_txd_still_idle", 32'(txd), 32'd1);
    stepClock;
    checkOutput("t1_txd_start", 32'(txd), 32'd0);
    checkOutput("t1_level_after_pop", 32'(level), 32'd0);
    waitFrames(1, FRAME + 20);
    checkOutput("t1_byte", rxByte(0), 32'h55);
    checkOutput("t1_start_edge", rxStartAt(0), 32'(wEdge + 1));
    checkOutput("t1_done_pulse", 32'(tx_done), 32'd1);
    checkOutput("t1_busy_in_stop", 32'(busy), 32'd1);
    stepClock;
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);
    checkOutput("t1_done_low", 32'(tx_done), 32'd0);
    checkOutput("t1_txd_idle", 32'(txd), 32'd1);

    // 2: back-to-back frames
    $display("[TB] back-to-back");
    repeat (4) stepClock;
    clearRx();
    applyStimulus(1'b1, 8'hA5);
    stepClock;
    wEdge = cyc;
    applyStimulus(1'b1, 8'h3C);
    stepClock;
    applyStimulus(1'b1, 8'hFF);
    stepClock;
    applyStimulus(1'b0, 8'h00);
    waitFrames(3, 3 * FRAME + 20);
    checkOutput("t2_byte0", rxByte(0), 32'hA5);
    checkOutput("t2_byte1", rxByte(1), 32'h3C);
    checkOutput("t2_byte2", rxByte(2), 32'hFF);
    checkOutput("t2_first_start", rxStartAt(0), 32'(wEdge + 1));
    checkOutput("t2_gap01", rxStartAt(1) - rxStartAt(0), 32'(FRAME));
    checkOutput("t2_gap12", rxStartAt(2) - rxStartAt(1), 32'(FRAME));
    stepClock;
    checkOutput("t2_total_len", 32'(cyc) - rxStartAt(0), 32'(3 * FRAME));
    checkOutput("t2_busy_idle", 32'(busy), 32'd0);

    // 3: hold wr_en over a full FIFO
    $display("[TB] full fifo");
    repeat (4) stepClock;
    clearRx();
    accepted = 0;
    maxLevel = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (wr_ready === 1'b1) accepted++;
      stepClock;
      if (int'(level) > maxLevel) maxLevel = int'(level);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_accepted", 32'(accepted), 32'd9);
    checkOutput("t3_max_level", 32'(maxLevel), 32'd8);
    checkOutput("t3_ready_low", 32'(wr_ready), 32'd0);
    waitFrames(9, 9 * FRAME + 40);
    repeat (2 * FRAME) stepClock;
    checkOutput("t3_frame_count", 32'(rxQ.size()), 32'd9);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("t3_byte%0d", i), rxByte(i), 32'(i));
    checkOutput("t3_busy_idle", 32'(busy), 32'd0);

    // 4: refill in the cycle after a pop from a full FIFO
    $display("[TB] push after pop at full");
    repeat (4) stepClock;
    clearRx();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(16 + i));
      stepClock;
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_full", 32'(level), 32'd8);
    budget = FRAME + 20;
    while (tx_done !== 1'b1 && budget > 0) begin
      stepClock;
      budget--;
    end
    checkOutput("t4_done_seen", 32'(tx_done), 32'd1);
    checkOutput("t4_full_at_stop", 32'(level), 32'd8);
    stepClock;
    checkOutput("t4_level_after_pop", 32'(level), 32'd7);
    checkOutput("t4_ready_after_pop", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, 8'h77);
    stepClock;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_level_refill", 32'(level), 32'd8);
    waitFrames(10, 10 * FRAME + 40);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("t4_byte%0d", i), rxByte(i), 32'(16 + i));
    checkOutput("t4_last_byte", rxByte(9), 32'h77);

    // 5: asynchronous reset during data bit 3 of 0x81
    $display("[TB] reset mid-frame");
    repeat (4) stepClock;
    clearRx();
    applyStimulus(1'b1, 8'h81);
    stepClock;
    applyStimulus(1'b1, 8'h99);
    stepClock;
    applyStimulus(1'b0, 8'h00);
    repeat (70) stepClock;
    checkOutput("t5_bit3_low", 32'(txd), 32'd0);
    checkOutput("t5_level_pre", 32'(level), 32'd1);
    checkOutput("t5_busy_pre", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_txd", 32'(txd), 32'd1);
    checkOutput("t5_rst_level", 32'(level), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_ready", 32'(wr_ready), 32'd1);
    checkOutput("t5_rst_done", 32'(tx_done), 32'd0);
    repeat (3) stepClock;
    #1 rst_n = 1'b1;
    stepClock;
    clearRx();
    applyStimulus(1'b1, 8'h42);
    stepClock;
    wEdge = cyc;
    applyStimulus(1'b0, 8'h00);
    waitFrames(1, FRAME + 20);
    repeat (FRAME + 40) stepClock;
    checkOutput("t5_frame_count", 32'(rxQ.size()), 32'd1);
    checkOutput("t5_byte", rxByte(0), 32'h42);
    checkOutput("t5_start_edge", rxStartAt(0), 32'(wEdge + 1));

    // 6: 20 single bytes through wrapping pointers
    $display("[TB] pointer wrap");
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'(i * 37 + 11);
      clearRx();
      applyStimulus(1'b1, b);
      stepClock;
      applyStimulus(1'b0, 8'h00);
      waitFrames(1, FRAME + 20);
      checkOutput($sformatf("t6_byte%0d", i), rxByte(0), 32'(b));
      stepClock;
    end
    checkOutput("t6_level_empty", 32'(level), 32'd0);
    checkOutput("t6_busy_idle", 32'(busy), 32'd0);

    checkOutput("mon_shape_errors", 32'(shapeErr), 32'd0);
    checkOutput("mon_done_errors", 32'(doneErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
